// File: rtl/prio_pkg.sv
// Shared definitions for the priority encoder / arbiter family.
//   MODE_FIXED / MODE_RR : values of the mode select input.
//   idx_width(n)         : width of a binary index into n lines, at least 1.
package prio_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // A single request line still needs a one-bit index port.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/prio_encoder_arb_if.sv
// Request / grant bus of prio_encoder_arb.
//   mode      : 0 fixed priority, 1 round-robin
//   req_in    : N level-sampled request bits
//   out_ready : consumer accepts out_idx this cycle
//   out_valid : out_idx holds a granted index
//   out_idx   : binary index of the grant (W bits)
//   nr        : nothing pending and no grant held
//   pending   : sticky pending register, for observability
// master = arbiter side, slave = requester/consumer side.
interface prio_encoder_arb_if
  import prio_pkg::*;
#(
  parameter int N = 8
);
  localparam int W = idx_width(N);

  logic         mode;
  logic [N-1:0] req_in;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic         nr;
  logic [N-1:0] pending;

  modport master (
    input  mode, req_in, out_ready,
    output out_valid, out_idx, nr, pending
  );

  modport slave (
    output mode, req_in, out_ready,
    input  out_valid, out_idx, nr, pending
  );

endinterface

// File: rtl/prio_pick.sv
// Combinational winner selection over N available lines.
//   avail      : candidate bits
//   last       : index of the previous winner (round-robin pointer)
//   mode       : MODE_FIXED (highest index wins) or MODE_RR
//   any        : at least one candidate
//   win_idx    : binary index of the winner (0 when nothing is available)
//   win_onehot : one-hot of the winner (all zero when nothing is available)
module prio_pick
  import prio_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]            avail,
  input  logic [idx_width(N)-1:0] last,
  input  logic                    mode,
  output logic                    any,
  output logic [idx_width(N)-1:0] win_idx,
  output logic [N-1:0]            win_onehot
);

  localparam int W = idx_width(N);

  // Highest set bit of v; later iterations override, so the top bit wins.
  function automatic logic [W-1:0] highest(input logic [N-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = W'(i);
    end
    return r;
  endfunction

  logic [N-1:0] below_last;
  logic [N-1:0] rr_lo;
  logic [W-1:0] hi_all;
  logic [W-1:0] hi_lo;

  // The round-robin order last-1 .. 0, N-1 .. last equals: highest set bit
  // strictly below last if there is one, otherwise the highest set bit
  // overall. With last=0 the lower half is empty and RR matches fixed.
  always_comb begin
    below_last = '0;
    for (int i = 0; i < N; i++) begin
      below_last[i] = (i < int'(last));
    end
  end

  assign rr_lo  = avail & below_last;
  assign hi_all = highest(avail);
  assign hi_lo  = highest(rr_lo);
  assign any    = |avail;

  always_comb begin
    win_idx = hi_all;
    if ((mode == MODE_RR) && (|rr_lo)) win_idx = hi_lo;
  end

  // Built by compare rather than by indexing so that a non-power-of-2 N
  // never sees an out-of-range select.
  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < N; i++) begin
      win_onehot[i] = any && (win_idx == W'(i));
    end
  end

endmodule

// File: rtl/prio_encoder_arb.sv
// Registered priority encoder / arbiter. Request bits collect in a sticky
// pending register; each cycle the output slot is free, one winner (fixed
// priority or round-robin) is moved to a valid/ready output as its index.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears every register, nr=1
//   bus   : prio_encoder_arb_if master modport (mode, req_in, out_ready in;
//           out_valid, out_idx, nr, pending out)
module prio_encoder_arb
  import prio_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                reset,
  prio_encoder_arb_if.master  bus
);

  localparam int W = idx_width(N);

  logic [N-1:0] pending_p1;
  logic         vld_p1;
  logic [W-1:0] idx_p1;
  logic [W-1:0] last_p1;
  logic         nr_p1;

  logic [N-1:0] avail_p0;
  logic         any_p0;
  logic [W-1:0] win_idx_p0;
  logic [N-1:0] win_onehot_p0;
  logic         load_p0;

  logic [N-1:0] pending_nx;
  logic         vld_nx;
  logic [W-1:0] idx_nx;
  logic [W-1:0] last_nx;
  logic         nr_nx;

  // ---- stage p0: merge new requests, pick a winner ----
  // A request arriving in the same cycle as a grant of its bit merges into
  // avail and is cleared by that grant, i.e. absorbed.
  assign avail_p0 = pending_p1 | bus.req_in;

  prio_pick #(.N(N)) u_pick (
    .avail      (avail_p0),
    .last       (last_p1),
    .mode       (bus.mode),
    .any        (any_p0),
    .win_idx    (win_idx_p0),
    .win_onehot (win_onehot_p0)
  );

  assign load_p0 = (!vld_p1 || bus.out_ready) && any_p0;

  always_comb begin
    pending_nx = avail_p0;
    vld_nx     = vld_p1;
    idx_nx     = idx_p1;
    last_nx    = last_p1;
    if (load_p0) begin
      pending_nx = avail_p0 & ~win_onehot_p0;
      vld_nx     = 1'b1;
      idx_nx     = win_idx_p0;
      last_nx    = win_idx_p0;
    end else if (vld_p1 && bus.out_ready) begin
      // Accepted with nothing to replace it: out_idx keeps its last value.
      vld_nx = 1'b0;
    end
    // Registered alongside the others so nr never disagrees with them.
    nr_nx = (pending_nx == '0) && !vld_nx;
  end

  // ---- stage p1: pending, output, pointer and nr registers ----
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_p1 <= '0;
      vld_p1     <= 1'b0;
      idx_p1     <= '0;
      last_p1    <= '0;
      nr_p1      <= 1'b1;
    end else begin
      pending_p1 <= pending_nx;
      vld_p1     <= vld_nx;
      idx_p1     <= idx_nx;
      last_p1    <= last_nx;
      nr_p1      <= nr_nx;
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_idx   = idx_p1;
  assign bus.nr        = nr_p1;
  assign bus.pending   = pending_p1;

endmodule

// File: tb/tb_prio_encoder_arb.sv
module tb_prio_encoder_arb;

  logic clk;
  logic reset;

  prio_encoder_arb_if #(.N(8)) a ();
  prio_encoder_arb_if #(.N(5)) b ();

  prio_encoder_arb #(.N(8)) dut_a (.clk(clk), .reset(reset), .bus(a));
  prio_encoder_arb #(.N(5)) dut_b (.clk(clk), .reset(reset), .bus(b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int qa[$];
  int qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every accepted grant pops one expected index.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (a.out_valid === 1'b1 && a.out_ready === 1'b1) begin
        if (qa.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL a_unexpected_grant: got idx %0d, expected no grant", a.out_idx);
        end else begin
          e = qa.pop_front();
          check("a_grant_idx", 32'(a.out_idx), e);
        end
      end
    end
  end

  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (b.out_valid === 1'b1) check("b_idx_range", 32'(b.out_idx <= 3'd4), 1);
      if (b.out_valid === 1'b1 && b.out_ready === 1'b1) begin
        if (qb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL b_unexpected_grant: got idx %0d, expected no grant", b.out_idx);
        end else begin
          e = qb.pop_front();
          check("b_grant_idx", 32'(b.out_idx), e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with all requests high: they must be discarded.
    reset = 1'b1;
    a.mode = 1'b0; a.req_in = 8'hFF; a.out_ready = 1'b0;
    b.mode = 1'b0; b.req_in = 5'h1F; b.out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    a.req_in = '0; b.req_in = '0; a.out_ready = 1'b1;
    check("rst_valid", 32'(a.out_valid), 0);
    check("rst_nr", 32'(a.nr), 1);
    check("rst_pending", 32'(a.pending), 0);
    check("rst_idx", 32'(a.out_idx), 0);
    check("rst_b_nr", 32'(b.nr), 1);
    check("rst_b_pending", 32'(b.pending), 0);
    repeat (3) begin
      tick();
      check("rst_no_grant", 32'(a.out_valid), 0);
      check("rst_nr_held", 32'(a.nr), 1);
    end

    // Fixed priority drain of 0010_0110 -> 5, 2, 1.
    qa.push_back(5); qa.push_back(2); qa.push_back(1);
    a.req_in = 8'b0010_0110;
    tick();
    a.req_in = '0;
    check("fix_latency_idx", 32'(a.out_idx), 5);
    check("fix_pending", 32'(a.pending), 8'h06);
    tick(); tick(); tick();
    check("fix_end_valid", 32'(a.out_valid), 0);
    check("fix_end_nr", 32'(a.nr), 1);

    // Backpressure: grant 7 held, bit0 stays pending.
    a.out_ready = 1'b0;
    a.req_in = 8'h81;
    tick();
    a.req_in = '0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check("bp_valid", 32'(a.out_valid), 1);
      check("bp_idx", 32'(a.out_idx), 7);
      check("bp_pending", 32'(a.pending), 8'h01);
      check("bp_nr", 32'(a.nr), 0);
    end
    qa.push_back(7); qa.push_back(0);
    a.out_ready = 1'b1;
    tick();
    check("bp_second_idx", 32'(a.out_idx), 0);
    check("bp_second_valid", 32'(a.out_valid), 1);
    tick();
    check("bp_end_nr", 32'(a.nr), 1);
    check("bp_end_valid", 32'(a.out_valid), 0);

    // Round-robin with all requests held, then back to fixed priority.
    // The twelfth grant is still on the output when reset drops it.
    qa.push_back(7); qa.push_back(6); qa.push_back(5); qa.push_back(4);
    qa.push_back(3); qa.push_back(2); qa.push_back(1); qa.push_back(0);
    qa.push_back(7); qa.push_back(7); qa.push_back(7);
    a.mode = 1'b1;
    a.req_in = 8'hFF;
    repeat (9) tick();
    a.mode = 1'b0;
    repeat (3) begin
      tick();
      check("fix_after_rr", 32'(a.out_idx), 7);
    end
    a.out_ready = 1'b0;
    a.req_in = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rr_cleared_pending", 32'(a.pending), 0);
    check("rr_cleared_valid", 32'(a.out_valid), 0);

    // Same-cycle re-request is absorbed; a later pulse grants again.
    a.mode = 1'b0;
    a.req_in = 8'h20;
    tick();
    a.req_in = 8'h10;
    tick();
    check("sc_pending_set", 32'(a.pending), 8'h10);
    check("sc_held_idx", 32'(a.out_idx), 5);
    qa.push_back(5); qa.push_back(4); qa.push_back(4);
    a.out_ready = 1'b1;
    tick();
    check("sc_grant_idx", 32'(a.out_idx), 4);
    check("sc_absorbed", 32'(a.pending), 0);
    a.req_in = 8'h10;
    tick();
    check("sc_regrant_idx", 32'(a.out_idx), 4);
    check("sc_regrant_valid", 32'(a.out_valid), 1);
    check("sc_regrant_pending", 32'(a.pending), 0);
    a.req_in = '0;
    tick();
    check("sc_end_valid", 32'(a.out_valid), 0);
    check("sc_end_nr", 32'(a.nr), 1);

    // Reset mid-operation: pending 0F, grant 3 held, last=3.
    a.out_ready = 1'b0;
    a.req_in = 8'h08;
    tick();
    a.req_in = 8'h0F;
    tick();
    check("mid_pending", 32'(a.pending), 8'h0F);
    check("mid_valid", 32'(a.out_valid), 1);
    check("mid_idx", 32'(a.out_idx), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a.req_in = '0;
    check("mid_rst_valid", 32'(a.out_valid), 0);
    check("mid_rst_nr", 32'(a.nr), 1);
    check("mid_rst_pending", 32'(a.pending), 0);
    check("mid_rst_idx", 32'(a.out_idx), 0);
    // last was cleared, so RR starts from the top: 3 then 2, 1, 0.
    qa.push_back(3); qa.push_back(2); qa.push_back(1); qa.push_back(0);
    a.mode = 1'b1;
    a.out_ready = 1'b1;
    a.req_in = 8'h0F;
    tick();
    a.req_in = '0;
    check("mid_rr_first", 32'(a.out_idx), 3);
    repeat (4) tick();
    check("mid_end_valid", 32'(a.out_valid), 0);
    check("mid_end_nr", 32'(a.nr), 1);

    // N=5 round-robin wraps at 4; sixth grant checked on the output.
    a.out_ready = 1'b0;
    a.mode = 1'b0;
    qb.push_back(4); qb.push_back(3); qb.push_back(2); qb.push_back(1); qb.push_back(0);
    b.mode = 1'b1;
    b.out_ready = 1'b1;
    b.req_in = 5'h1F;
    repeat (6) tick();
    check("n5_wrap_idx", 32'(b.out_idx), 4);
    b.out_ready = 1'b0;
    b.req_in = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("n5_rst_nr", 32'(b.nr), 1);
    check("n5_rst_pending", 32'(b.pending), 0);
    check("n5_rst_valid", 32'(b.out_valid), 0);
    tick();

    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
